// File: rtl/sram_stage_scheduler.sv
// Decode-pipeline sequencer: runs UART load, M1 and M2 once each in order,
// owns the shared SRAM port, and muxes it to whichever stage is active.
// A per-stage watchdog catches a stage that never finishes. Cycle counters
// report how long M1 and M2 took on the last run.
module sram_stage_scheduler #(
  parameter logic [31:0] TIMEOUT = 32'd4000000,
  parameter int          CNT_W   = 32
) (
  input  logic             CLOCK_50_I,
  input  logic             reset,
  input  logic             go,
  input  logic             skip_load,
  output logic             c0_start,
  output logic             c1_start,
  output logic             c2_start,
  input  logic             c0_done,
  input  logic             c1_done,
  input  logic             c2_done,
  input  logic [17:0]      c0_address,
  input  logic [17:0]      c1_address,
  input  logic [17:0]      c2_address,
  input  logic [15:0]      c0_write_data,
  input  logic [15:0]      c1_write_data,
  input  logic [15:0]      c2_write_data,
  input  logic             c0_we_n,
  input  logic             c1_we_n,
  input  logic             c2_we_n,
  output logic [17:0]      SRAM_address,
  output logic [15:0]      SRAM_write_data,
  output logic             SRAM_we_n,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             decode_done,
  output logic             error,
  output logic [CNT_W-1:0] m1_cycles,
  output logic [CNT_W-1:0] m2_cycles
);

  // state  | meaning
  // S_IDLE | no decode running, bus parked (owner 3)
  // S_LOAD | client 0 (UART load) owns the bus
  // S_M1   | client 1 (upsample / colour convert) owns the bus
  // S_M2   | client 2 owns the bus
  // S_GAP  | one dead cycle between owners, next_stage says who is next
  // S_ERR  | a stage overran the watchdog; parked until go or reset
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_M1   = 3'd2,
    S_M2   = 3'd3,
    S_GAP  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [1:0]       NO_OWNER = 2'd3;

  state_t      state;
  logic [1:0]  next_stage;
  logic        started;
  logic [31:0] wd_cnt;
  logic        done_sel;

  // Done of the client that owns the current run state; others are ignored.
  always_comb begin
    done_sel = 1'b0;
    case (state)
      S_LOAD:  done_sel = c0_done;
      S_M1:    done_sel = c1_done;
      S_M2:    done_sel = c2_done;
      default: done_sel = 1'b0;
    endcase
  end

  // Bus mux straight off the registered owner so client timing is untouched.
  always_comb begin
    SRAM_address    = 18'd0;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    case (owner)
      2'd0: begin
        SRAM_address    = c0_address;
        SRAM_write_data = c0_write_data;
        SRAM_we_n       = c0_we_n;
      end
      2'd1: begin
        SRAM_address    = c1_address;
        SRAM_write_data = c1_write_data;
        SRAM_we_n       = c1_we_n;
      end
      2'd2: begin
        SRAM_address    = c2_address;
        SRAM_write_data = c2_write_data;
        SRAM_we_n       = c2_we_n;
      end
      default: begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

  // Stage sequencer with watchdog (down-counter, terminal count 0) and cycle counters.
  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      state       <= S_IDLE;
      next_stage  <= 2'd1;
      started     <= 1'b0;
      wd_cnt      <= 32'd0;
      owner       <= NO_OWNER;
      c0_start    <= 1'b0;
      c1_start    <= 1'b0;
      c2_start    <= 1'b0;
      busy        <= 1'b0;
      decode_done <= 1'b0;
      error       <= 1'b0;
      m1_cycles   <= '0;
      m2_cycles   <= '0;
    end else begin
      c0_start    <= 1'b0;
      c1_start    <= 1'b0;
      c2_start    <= 1'b0;
      decode_done <= 1'b0;
      case (state)
        S_IDLE, S_ERR: begin
          if (go) begin
            busy    <= 1'b1;
            error   <= 1'b0;
            started <= 1'b0;
            wd_cnt  <= TIMEOUT - 32'd1;
            if (skip_load) begin
              state     <= S_M1;
              owner     <= 2'd1;
              c1_start  <= 1'b1;
              m1_cycles <= '0;
            end else begin
              state    <= S_LOAD;
              owner    <= 2'd0;
              c0_start <= 1'b1;
            end
          end
        end
        S_LOAD, S_M1, S_M2: begin
          // The pulse cycle itself never counts as done; arm after it.
          started <= 1'b1;
          if (state == S_M1 && m1_cycles != CNT_MAX) m1_cycles <= m1_cycles + CNT_ONE;
          if (state == S_M2 && m2_cycles != CNT_MAX) m2_cycles <= m2_cycles + CNT_ONE;
          if (started && done_sel) begin
            started <= 1'b0;
            owner   <= NO_OWNER;
            case (state)
              S_LOAD: begin
                state      <= S_GAP;
                next_stage <= 2'd1;
              end
              S_M1: begin
                state      <= S_GAP;
                next_stage <= 2'd2;
              end
              default: begin
                state       <= S_IDLE;
                busy        <= 1'b0;
                decode_done <= 1'b1;
              end
            endcase
          end else if (wd_cnt == 32'd0) begin
            state   <= S_ERR;
            started <= 1'b0;
            owner   <= NO_OWNER;
            busy    <= 1'b0;
            error   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt - 32'd1;
          end
        end
        S_GAP: begin
          started <= 1'b0;
          wd_cnt  <= TIMEOUT - 32'd1;
          owner   <= next_stage;
          if (next_stage == 2'd1) begin
            state     <= S_M1;
            c1_start  <= 1'b1;
            m1_cycles <= '0;
          end else begin
            state     <= S_M2;
            c2_start  <= 1'b1;
            m2_cycles <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          owner <= NO_OWNER;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stage_scheduler.sv
// Directed bench for sram_stage_scheduler with a short watchdog (TIMEOUT = 100).
module tb_sram_stage_scheduler;

  logic        clk = 1'b0;
  logic        reset, go, skip_load;
  logic        c0_start, c1_start, c2_start;
  logic        c0_done, c1_done, c2_done;
  logic [17:0] c0_address, c1_address, c2_address;
  logic [15:0] c0_write_data, c1_write_data, c2_write_data;
  logic        c0_we_n, c1_we_n, c2_we_n;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [1:0]  owner;
  logic        busy, decode_done, error;
  logic [31:0] m1_cycles, m2_cycles;

  int vectors = 0;
  int miscompares = 0;

  int s0_cnt = 0, s1_cnt = 0, s2_cnt = 0, dd_cnt = 0;
  logic [1:0] last_owner = 2'd3;
  logic [1:0] owner_seq[$];

  sram_stage_scheduler #(.TIMEOUT(32'd100), .CNT_W(32)) dut (
    .CLOCK_50_I(clk), .reset(reset), .go(go), .skip_load(skip_load),
    .c0_start(c0_start), .c1_start(c1_start), .c2_start(c2_start),
    .c0_done(c0_done), .c1_done(c1_done), .c2_done(c2_done),
    .c0_address(c0_address), .c1_address(c1_address), .c2_address(c2_address),
    .c0_write_data(c0_write_data), .c1_write_data(c1_write_data), .c2_write_data(c2_write_data),
    .c0_we_n(c0_we_n), .c1_we_n(c1_we_n), .c2_we_n(c2_we_n),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .owner(owner), .busy(busy), .decode_done(decode_done), .error(error),
    .m1_cycles(m1_cycles), .m2_cycles(m2_cycles)
  );

  always #5 clk = ~clk;

  // Pulse counters and owner-change log, sampled mid-cycle.
  always @(negedge clk) begin
    if (c0_start === 1'b1) s0_cnt <= s0_cnt + 1;
    if (c1_start === 1'b1) s1_cnt <= s1_cnt + 1;
    if (c2_start === 1'b1) s2_cnt <= s2_cnt + 1;
    if (decode_done === 1'b1) dd_cnt <= dd_cnt + 1;
    if (owner !== last_owner) begin
      owner_seq.push_back(owner);
      last_owner <= owner;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int s0_snap, s1_snap, s2_snap, dd_snap;
    logic [1:0] exp_seq [6];
    exp_seq = '{2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd3};

    reset = 1'b1; go = 1'b0; skip_load = 1'b0;
    c0_done = 1'b0; c1_done = 1'b0; c2_done = 1'b0;
    c0_address = 18'h11111; c1_address = 18'h01234; c2_address = 18'h22222;
    c0_write_data = 16'h1111; c1_write_data = 16'h5555; c2_write_data = 16'h2222;
    c0_we_n = 1'b0; c1_we_n = 1'b1; c2_we_n = 1'b1;
    tick(); tick();

    // reset state
    chk("rst_owner", owner, 2'd3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_done", decode_done, 1'b0);
    chk("rst_we_n", SRAM_we_n, 1'b1);
    chk("rst_addr", SRAM_address, 18'd0);
    chk("rst_data", SRAM_write_data, 16'd0);
    chk("rst_m1", m1_cycles, 32'd0);
    chk("rst_m2", m2_cycles, 32'd0);
    chk("rst_c0_start", c0_start, 1'b0);
    reset = 1'b0;
    c0_we_n = 1'b1;
    tick();
    owner_seq.delete();

    // full decode, done 10/20/30 cycles after each start
    go = 1'b1; skip_load = 1'b0;
    tick();
    go = 1'b0;
    chk("load_c0_start", c0_start, 1'b1);
    chk("load_owner", owner, 2'd0);
    chk("load_busy", busy, 1'b1);
    chk("load_addr", SRAM_address, 18'h11111);
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (9) tick();
    c0_done = 1'b1;
    tick();
    c0_done = 1'b0;
    chk("gap1_owner", owner, 2'd3);
    chk("gap1_we_n", SRAM_we_n, 1'b1);
    tick();
    chk("m1_c1_start", c1_start, 1'b1);
    chk("m1_owner", owner, 2'd1);
    chk("m1_cnt_start", m1_cycles, 32'd0);
    repeat (20) tick();
    c1_done = 1'b1;
    tick();
    c1_done = 1'b0;
    chk("m1_cycles_21", m1_cycles, 32'd21);
    chk("gap2_owner", owner, 2'd3);
    tick();
    chk("m2_c2_start", c2_start, 1'b1);
    chk("m2_owner", owner, 2'd2);
    repeat (30) tick();
    c2_done = 1'b1;
    tick();
    c2_done = 1'b0;
    chk("run1_decode_done", decode_done, 1'b1);
    chk("run1_busy", busy, 1'b0);
    chk("run1_owner", owner, 2'd3);
    chk("m2_cycles_31", m2_cycles, 32'd31);
    tick();
    chk("run1_done_pulse_end", decode_done, 1'b0);
    chk("run1_m1_hold", m1_cycles, 32'd21);
    chk("run1_c0_starts", s0_cnt, 1);
    chk("run1_c1_starts", s1_cnt, 1);
    chk("run1_c2_starts", s2_cnt, 1);
    chk("run1_done_pulses", dd_cnt, 1);
    chk("owner_seq_len", owner_seq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < owner_seq.size()) chk($sformatf("owner_seq_%0d", i), owner_seq[i], exp_seq[i]);
    end

    // skip_load run: bus follows client 1 in the same cycle
    s0_snap = s0_cnt; s1_snap = s1_cnt; s2_snap = s2_cnt;
    c1_address = 18'h25800; c1_we_n = 1'b0; c1_write_data = 16'hABCD;
    go = 1'b1; skip_load = 1'b1;
    tick();
    go = 1'b0; skip_load = 1'b0;
    chk("skip_owner", owner, 2'd1);
    chk("skip_c1_start", c1_start, 1'b1);
    chk("skip_addr", SRAM_address, 18'h25800);
    chk("skip_data", SRAM_write_data, 16'hABCD);
    chk("skip_we_n", SRAM_we_n, 1'b0);
    c1_address = 18'h00123;
    #1;
    chk("skip_addr_comb", SRAM_address, 18'h00123);

    // foreign done / foreign we_n ignored during M1
    c2_done = 1'b1; c0_we_n = 1'b0; c1_we_n = 1'b1;
    tick(); tick(); tick();
    chk("foreign_owner", owner, 2'd1);
    chk("foreign_we_n", SRAM_we_n, 1'b1);
    chk("foreign_busy", busy, 1'b1);
    c1_we_n = 1'b0;
    #1;
    chk("foreign_we_n_c1", SRAM_we_n, 1'b0);
    c2_done = 1'b0; c0_we_n = 1'b1; c1_we_n = 1'b1;

    // c1_done held high for 50 cycles; c2_done in the c2_start cycle
    c1_done = 1'b1;
    tick();
    chk("held_gap_owner", owner, 2'd3);
    chk("held_m1_cycles", m1_cycles, 32'd4);
    tick();
    chk("held_m2_owner", owner, 2'd2);
    chk("held_c2_start", c2_start, 1'b1);
    c2_done = 1'b1;
    tick();
    c2_done = 1'b0;
    chk("early_done_owner", owner, 2'd2);
    chk("early_done_busy", busy, 1'b1);
    repeat (47) tick();
    c1_done = 1'b0;
    chk("held_owner_after", owner, 2'd2);
    chk("skip_no_c0_start", s0_cnt - s0_snap, 0);
    chk("held_one_c1_start", s1_cnt - s1_snap, 1);
    chk("held_one_c2_start", s2_cnt - s2_snap, 1);

    // go during busy, then reset mid-M2
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("busy_go_no_start", s0_cnt - s0_snap, 0);
    c2_we_n = 1'b0;
    #1;
    chk("m2_we_n_client", SRAM_we_n, 1'b0);
    dd_snap = dd_cnt; s1_snap = s1_cnt; s2_snap = s2_cnt; s0_snap = s0_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_owner", owner, 2'd3);
    chk("midrst_we_n", SRAM_we_n, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_m2", m2_cycles, 32'd0);
    repeat (3) tick();
    chk("midrst_no_done", dd_cnt - dd_snap, 0);
    chk("midrst_no_start", (s0_cnt - s0_snap) + (s1_cnt - s1_snap) + (s2_cnt - s2_snap), 0);
    c2_we_n = 1'b1;

    // watchdog: client 1 never completes
    c1_we_n = 1'b0;
    go = 1'b1; skip_load = 1'b1;
    tick();
    go = 1'b0; skip_load = 1'b0;
    chk("wd_owner_start", owner, 2'd1);
    repeat (99) tick();
    chk("wd_still_m1", owner, 2'd1);
    chk("wd_no_error_yet", error, 1'b0);
    tick();
    chk("wd_error", error, 1'b1);
    chk("wd_owner", owner, 2'd3);
    chk("wd_we_n", SRAM_we_n, 1'b1);
    chk("wd_busy", busy, 1'b0);
    chk("wd_m1_cycles", m1_cycles, 32'd100);
    repeat (5) tick();
    chk("wd_error_sticky", error, 1'b1);
    chk("wd_no_done", dd_cnt - dd_snap, 0);
    c1_we_n = 1'b1;
    go = 1'b1; skip_load = 1'b0;
    tick();
    go = 1'b0;
    chk("err_go_error", error, 1'b0);
    chk("err_go_owner", owner, 2'd0);
    chk("err_go_c0_start", c0_start, 1'b1);
    chk("err_go_busy", busy, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
